// File: rtl/pcie_ts_pkg.sv
// Shared constants and types for the PCIe receive-side TS1/TS2 detector.
package pcie_ts_pkg;

  localparam logic [7:0] COM    = 8'hBC;
  localparam logic [7:0] PAD    = 8'hF7;
  localparam logic [7:0] TS1_ID = 8'h4A;
  localparam logic [7:0] TS2_ID = 8'h45;

  // Bit positions inside the training-control symbol.
  localparam int CTRL_HOT_RESET  = 0;
  localparam int CTRL_DISABLE    = 1;
  localparam int CTRL_LOOPBACK   = 2;
  localparam int CTRL_SCRAMBLE_OFF = 3;

  localparam logic [3:0] LAST_IDX = 4'd15;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_BODY = 1'b1
  } parse_state_e;

  typedef enum logic [1:0] {
    TS_NONE = 2'd0,
    TS1     = 2'd1,
    TS2     = 2'd2
  } ts_type_e;

  typedef struct packed {
    ts_type_e    ts_type;
    logic [7:0]  link;
    logic [7:0]  lane;
    logic [3:0]  ctrl;
  } ts_fields_t;

  function automatic ts_type_e id_to_type(input logic [7:0] id);
    return (id == TS2_ID) ? TS2 : TS1;
  endfunction

endpackage

// File: rtl/pcie_ts_parser.sv
// Symbol-level TS1/TS2 parser: strobes good/bad on the deciding symbol and
// holds the fields captured from the set currently being parsed.
module pcie_ts_parser
  import pcie_ts_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       sym_valid,
  input  logic [7:0] sym_data,
  input  logic       sym_is_k,
  output logic       good,
  output logic       bad,
  output ts_fields_t fields
);

  parse_state_e state;
  logic [3:0]   idx;
  logic         is_com;
  logic         sym_ok;
  logic [7:0]   id_sym;

  assign is_com = sym_is_k && (sym_data == COM);

  // Legality of the current symbol at its body position and the resulting strobes.
  always_comb begin
    good   = 1'b0;
    bad    = 1'b0;
    sym_ok = 1'b0;
    id_sym = (fields.ts_type == TS2) ? TS2_ID : TS1_ID;
    case (idx)
      4'd1, 4'd2:       sym_ok = !sym_is_k || (sym_data == PAD);
      4'd3, 4'd4, 4'd5: sym_ok = !sym_is_k;
      4'd6:             sym_ok = !sym_is_k && ((sym_data == TS1_ID) || (sym_data == TS2_ID));
      default:          sym_ok = !sym_is_k && (sym_data == id_sym);
    endcase
    if (sym_valid && !clear && (state == ST_BODY)) begin
      if (is_com || !sym_ok) begin
        bad = 1'b1;
      end else if (idx == LAST_IDX) begin
        good = 1'b1;
      end else begin
        good = 1'b0;
      end
    end else begin
      bad = 1'b0;
    end
  end

  // Parser state, symbol index and field capture; a COM inside a body restarts at index 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_HUNT;
      idx    <= 4'd0;
      fields <= '0;
    end else if (clear) begin
      state  <= ST_HUNT;
      idx    <= 4'd0;
      fields <= '0;
    end else if (sym_valid) begin
      case (state)
        ST_HUNT: begin
          if (is_com) begin
            state <= ST_BODY;
            idx   <= 4'd1;
          end
        end
        ST_BODY: begin
          if (is_com) begin
            idx <= 4'd1;
          end else if (bad || good) begin
            state <= ST_HUNT;
            idx   <= 4'd0;
          end else begin
            idx <= idx + 4'd1;
            case (idx)
              4'd1:    fields.link    <= sym_data;
              4'd2:    fields.lane    <= sym_data;
              4'd5:    fields.ctrl    <= sym_data[3:0];
              4'd6:    fields.ts_type <= id_to_type(sym_data);
              default: ;
            endcase
          end
        end
        default: begin
          state <= ST_HUNT;
          idx   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pcie_ts_detector.sv
// Receive-side TS detector: consecutive identical TS counting, lock flags,
// last-good field reporting and a sticky no-TS timeout for the LTSSM.
module pcie_ts_detector
  import pcie_ts_pkg::*;
#(
  parameter int unsigned TS_COUNT_REQ   = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       sym_valid,
  input  logic [7:0] sym_data,
  input  logic       sym_is_k,
  output logic       ts_rcvd,
  output logic       ts_error,
  output logic       ts1_lock,
  output logic       ts2_lock,
  output logic [7:0] ts_link_num,
  output logic [7:0] ts_lane_num,
  output logic [3:0] ts_ctrl,
  output logic       ts_timeout
);

  localparam int unsigned CW = $clog2(TS_COUNT_REQ + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(TS_COUNT_REQ);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

  logic          good;
  logic          bad;
  ts_fields_t    parsed;
  ts_fields_t    held;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  ts_type_e      type_next;
  logic          match;
  logic [TW-1:0] tmo_cnt;

  pcie_ts_parser u_parser (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .sym_valid (sym_valid),
    .sym_data  (sym_data),
    .sym_is_k  (sym_is_k),
    .good      (good),
    .bad       (bad),
    .fields    (parsed)
  );

  // Next consecutive count: a zero count never matches, so the first set after clear counts 1.
  always_comb begin
    match      = (parsed == held) && (count != '0);
    count_next = count;
    type_next  = held.ts_type;
    if (good) begin
      type_next = parsed.ts_type;
      if (match) begin
        count_next = (count == CNT_MAX) ? count : count + CW'(1);
      end else begin
        count_next = CW'(1);
      end
    end else if (bad) begin
      count_next = '0;
    end else begin
      count_next = count;
    end
  end

  // Pulses, held fields, consecutive count and lock flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_rcvd  <= 1'b0;
      ts_error <= 1'b0;
      ts1_lock <= 1'b0;
      ts2_lock <= 1'b0;
      held     <= '0;
      count    <= '0;
    end else if (clear) begin
      ts_rcvd  <= 1'b0;
      ts_error <= 1'b0;
      ts1_lock <= 1'b0;
      ts2_lock <= 1'b0;
      held     <= '0;
      count    <= '0;
    end else begin
      ts_rcvd  <= good;
      ts_error <= bad;
      count    <= count_next;
      ts1_lock <= (count_next == CNT_MAX) && (type_next == TS1);
      ts2_lock <= (count_next == CNT_MAX) && (type_next == TS2);
      if (good) begin
        held <= parsed;
      end
    end
  end

  // No-good-TS watchdog; the flag is raised on the cycle after the counter saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt    <= '0;
      ts_timeout <= 1'b0;
    end else if (clear || good) begin
      tmo_cnt    <= '0;
      ts_timeout <= 1'b0;
    end else if (tmo_cnt == TMO_MAX) begin
      ts_timeout <= 1'b1;
    end else begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  assign ts_link_num = held.link;
  assign ts_lane_num = held.lane;
  assign ts_ctrl     = held.ctrl;

endmodule

// File: tb/tb_pcie_ts_detector.sv
// Scoreboard bench for pcie_ts_detector: directed TS streams push expected
// events; a negedge monitor pops and compares on every ts_rcvd/ts_error.
module tb_pcie_ts_detector;
  import pcie_ts_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic       sym_valid = 1'b0;
  logic [7:0] sym_data = 8'h00;
  logic       sym_is_k = 1'b0;
  logic       ts_rcvd, ts_error, ts1_lock, ts2_lock, ts_timeout;
  logic [7:0] ts_link_num, ts_lane_num;
  logic [3:0] ts_ctrl;

  typedef struct packed {
    logic       rcvd;
    logic       err;
    logic       l1;
    logic       l2;
    logic [7:0] link;
    logic [7:0] lane;
    logic [3:0] ctrl;
    logic       tmo;
  } ev_t;

  ev_t  exp_q[$];
  ev_t  act_ev, exp_ev;
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   err_cyc = -1;
  int   rcvd_cyc = -1;
  logic gaps_on = 1'b0;

  pcie_ts_detector #(.TS_COUNT_REQ(8), .TIMEOUT_CYCLES(1024)) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .sym_valid   (sym_valid),
    .sym_data    (sym_data),
    .sym_is_k    (sym_is_k),
    .ts_rcvd     (ts_rcvd),
    .ts_error    (ts_error),
    .ts1_lock    (ts1_lock),
    .ts2_lock    (ts2_lock),
    .ts_link_num (ts_link_num),
    .ts_lane_num (ts_lane_num),
    .ts_ctrl     (ts_ctrl),
    .ts_timeout  (ts_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every event the DUT presents must match the next expected entry.
  always @(negedge clk) begin
    if (ts_rcvd || ts_error) begin
      act_ev = {ts_rcvd, ts_error, ts1_lock, ts2_lock, ts_link_num, ts_lane_num, ts_ctrl, ts_timeout};
      if (ts_error) err_cyc = cyc;
      if (ts_rcvd) rcvd_cyc = cyc;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event act=%h req=none", act_ev);
      end else begin
        exp_ev = exp_q.pop_front();
        if (act_ev !== exp_ev) begin
          n_fail++;
          $display("FAIL event act=%h req=%h", act_ev, exp_ev);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s act=%h req=%h", name, act, req);
    end
  endtask

  task automatic push_ok(input logic l1, input logic l2, input logic [7:0] link,
                         input logic [7:0] lane, input logic [3:0] ctrl);
    exp_q.push_back({1'b1, 1'b0, l1, l2, link, lane, ctrl, 1'b0});
  endtask

  task automatic push_err(input logic [7:0] link, input logic [7:0] lane, input logic [3:0] ctrl);
    exp_q.push_back({1'b0, 1'b1, 1'b0, 1'b0, link, lane, ctrl, 1'b0});
  endtask

  task automatic idle();
    sym_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic sym(input logic k, input logic [7:0] d);
    if (gaps_on) repeat ($urandom_range(0, 2)) idle();
    sym_valid = 1'b1;
    sym_is_k  = k;
    sym_data  = d;
    @(posedge clk);
    #1;
    sym_valid = 1'b0;
    sym_is_k  = 1'b0;
  endtask

  // Body symbols 1..15; symbol bad_idx is replaced and optionally ends the burst.
  task automatic send_body(input logic [7:0] id, input logic [7:0] link, input logic link_k,
                           input logic [7:0] lane, input logic lane_k, input logic [3:0] ctrl,
                           input int bad_idx, input logic bad_k, input logic [7:0] bad_val,
                           input logic stop);
    logic       k;
    logic [7:0] d;
    for (int i = 1; i <= 15; i++) begin
      case (i)
        1:       begin k = link_k; d = link; end
        2:       begin k = lane_k; d = lane; end
        3:       begin k = 1'b0;   d = 8'h1F; end
        4:       begin k = 1'b0;   d = 8'h02; end
        5:       begin k = 1'b0;   d = {4'h0, ctrl}; end
        default: begin k = 1'b0;   d = id; end
      endcase
      if (i == bad_idx) begin
        k = bad_k;
        d = bad_val;
      end
      sym(k, d);
      if (i == bad_idx && stop) break;
    end
  endtask

  task automatic send_ts(input logic [7:0] id, input logic [7:0] link, input logic link_k,
                         input logic [7:0] lane, input logic lane_k, input logic [3:0] ctrl);
    sym(1'b1, COM);
    send_body(id, link, link_k, lane, lane_k, ctrl, 0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {7'd0, ts_rcvd, ts_error, ts1_lock, ts2_lock, ts_link_num, ts_lane_num, ts_ctrl, ts_timeout}, 32'd0);
    reset = 1'b0;

    // Timeout after 1024 cycles with no COM
    repeat (1023) @(posedge clk);
    #1;
    chk("timeout_1023", {31'd0, ts_timeout}, 32'd0);
    @(posedge clk);
    #1;
    chk("timeout_1024", {31'd0, ts_timeout}, 32'd1);

    // Eight back-to-back TS1 with PAD link/lane; the first also clears the timeout
    for (int j = 0; j < 8; j++) push_ok(j == 7, 1'b0, 8'hF7, 8'hF7, 4'h0);
    for (int j = 0; j < 8; j++) send_ts(TS1_ID, PAD, 1'b1, PAD, 1'b1, 4'h0);
    chk("ts1_lock_after_8", {31'd0, ts1_lock}, 32'd1);

    // Seven TS2 link 1, then nine TS2 link 2: lock on the 8th of the link-2 run
    for (int j = 0; j < 7; j++) push_ok(1'b0, 1'b0, 8'h01, 8'h00, 4'h0);
    for (int j = 0; j < 9; j++) push_ok(1'b0, j >= 7, 8'h02, 8'h00, 4'h0);
    for (int j = 0; j < 7; j++) send_ts(TS2_ID, 8'h01, 1'b0, 8'h00, 1'b0, 4'h0);
    for (int j = 0; j < 9; j++) send_ts(TS2_ID, 8'h02, 1'b0, 8'h00, 1'b0, 4'h0);
    chk("link_num_2", {24'd0, ts_link_num}, 32'h02);

    // Lock a TS1 stream, corrupt symbol 9, then the count restarts from 1
    for (int j = 0; j < 8; j++) push_ok(j == 7, 1'b0, 8'h05, 8'h03, 4'h0);
    push_err(8'h05, 8'h03, 4'h0);
    for (int j = 0; j < 8; j++) push_ok(j == 7, 1'b0, 8'h05, 8'h03, 4'h0);
    for (int j = 0; j < 8; j++) send_ts(TS1_ID, 8'h05, 1'b0, 8'h03, 1'b0, 4'h0);
    sym(1'b1, COM);
    send_body(TS1_ID, 8'h05, 1'b0, 8'h03, 1'b0, 4'h0, 9, 1'b0, TS2_ID, 1'b0);
    for (int j = 0; j < 8; j++) send_ts(TS1_ID, 8'h05, 1'b0, 8'h03, 1'b0, 4'h0);

    // COM at symbol 10 resyncs; the following body completes 15 cycles later
    push_err(8'h05, 8'h03, 4'h0);
    push_ok(1'b0, 1'b0, 8'h05, 8'h03, 4'h0);
    sym(1'b1, COM);
    send_body(TS1_ID, 8'h05, 1'b0, 8'h03, 1'b0, 4'h0, 10, 1'b1, COM, 1'b1);
    send_body(TS1_ID, 8'h05, 1'b0, 8'h03, 1'b0, 4'h0, 0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    #1;
    chk("resync_latency", rcvd_cyc - err_cyc, 32'd15);

    // Eight TS1 ctrl=1 with random valid gaps
    gaps_on = 1'b1;
    for (int j = 0; j < 8; j++) push_ok(j == 7, 1'b0, 8'h01, 8'h00, 4'h1);
    for (int j = 0; j < 8; j++) send_ts(TS1_ID, 8'h01, 1'b0, 8'h00, 1'b0, 4'h1);
    gaps_on = 1'b0;
    @(negedge clk);
    #1;
    chk("gapped_ctrl", {28'd0, ts_ctrl}, 32'h1);

    // Clear wins over a simultaneous COM; the body that follows must be ignored
    clear = 1'b1;
    sym(1'b1, COM);
    clear = 1'b0;
    chk("clear_outputs", {7'd0, ts_rcvd, ts_error, ts1_lock, ts2_lock, ts_link_num, ts_lane_num, ts_ctrl, ts_timeout}, 32'd0);
    send_body(TS1_ID, 8'h01, 1'b0, 8'h00, 1'b0, 4'h1, 0, 1'b0, 8'h00, 1'b0);
    push_ok(1'b0, 1'b0, 8'h01, 8'h00, 4'h1);
    send_ts(TS1_ID, 8'h01, 1'b0, 8'h00, 1'b0, 4'h1);

    // Asynchronous reset mid-TS discards the partial set
    sym(1'b1, COM);
    send_body(TS1_ID, 8'h01, 1'b0, 8'h00, 1'b0, 4'h1, 6, 1'b0, TS1_ID, 1'b1);
    reset = 1'b1;
    #1;
    chk("async_reset", {7'd0, ts_rcvd, ts_error, ts1_lock, ts2_lock, ts_link_num, ts_lane_num, ts_ctrl, ts_timeout}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    send_body(TS1_ID, 8'h01, 1'b0, 8'h00, 1'b0, 4'h1, 0, 1'b0, 8'h00, 1'b0);
    push_ok(1'b0, 1'b0, 8'h07, 8'h01, 4'h8);
    send_ts(TS2_ID, 8'h07, 1'b0, 8'h01, 1'b0, 4'h8);

    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
